psec_sca_sequencer: RTL and testbench
=====================================

# psec_sca_sequencer

Parametrised, fully synchronous successor to the single-channel PSEC5 digital block. It sequences N_BANKS fast SCA banks plus one slow bank in runtime-selectable group sizes, advancing on the synchronised discriminator edge. It snapshots the counter bus on stop and serialises the snapshot in SER_W-bit chunks. It sits between the per-channel analog front end (discriminator, bank counters) and the SPI readout logic.

## Interface
- N_BANKS, 4: fast banks; power of two, ≥2
- CNT_W, 10: counter width per bank
- SER_W, 8: serial chunk width
- SYNC_STAGES, 2: discriminator synchroniser depth, ≥2
- Derived: GW=$clog2($clog2(N_BANKS)+1); NCHUNK=ceil((N_BANKS+1)*CNT_W/SER_W); SW=$clog2(NCHUNK+1)
- CLK  in  1  sole clock
- RST  in  1  reset, synchronous, active-high
- INST_START, INST_STOP, INST_READOUT  in  1 each  single-cycle command pulses, CLK-synchronous
- GROUP_LOG2  in  GW  group size G=2**GROUP_LOG2 banks; values >log2(N_BANKS) clamp to G=N_BANKS
- DISCRIMINATOR_OUTPUT  in  1  asynchronous discriminator
- CNT  in  (N_BANKS+1)*CNT_W  counters; bank i at [i*CNT_W +: CNT_W], slow bank at index N_BANKS
- SELECT_REG  in  SW  chunk select
- LOAD_CNT_SER  in  1  load chunk into shifter
- SER_SHIFT  in  1  shift enable
- TRIG, TRIGC  out  N_BANKS  active-low bank write strobe / strobe-chain enables
- TRIGE  out  1  active-low slow-bank enable
- STATE  out  3  encoded state
- HIT_COUNT  out  $clog2(N_BANKS+1)  accepted discriminator edges since START
- CNT_SER  out  1  serial data, LSB first

## Operation
- States: INIT, STOPPED, SAMPLING, SLOW_ONLY, READOUT. Registers: ptr (base bank of the active group) and G.
- Command priority per cycle: RST > INST_START > INST_STOP > INST_READOUT > discriminator edge. Lower-priority events in the same cycle are dropped.
- INST_START from any state:
  - Capture G from GROUP_LOG2.
  - ptr=0, HIT_COUNT=0, enter SAMPLING.
  - GROUP_LOG2 is ignored at all other times.
- Discriminator edge: s[SYNC_STAGES-1] high while the previous sample was low.
  - In SAMPLING: ptr+=G, HIT_COUNT+=1 (saturating). If the new ptr is ≥N_BANKS, go to SLOW_ONLY.
  - In all other states: ignored.
  - A level held high advances exactly once.
- INST_STOP from any state: go to STOPPED and load snapshot←CNT. Snapshot is zero-extended to NCHUNK*SER_W.
- INST_READOUT: go to READOUT. Snapshot is unchanged.
- Trigger decode, bank i, in SAMPLING:
  - i in [ptr, ptr+G): TRIG=0, TRIGC=0.
  - i ≥ ptr+G: TRIG=1, TRIGC=0.
  - i < ptr: TRIG=1, TRIGC=1.
  - TRIGE=0.
- SLOW_ONLY: TRIG and TRIGC all 1, TRIGE=0.
- INIT, STOPPED, READOUT: all trigger outputs 1.
- Serialiser (shift register sreg, SER_W bits):
  - LOAD_CNT_SER loads sreg←chunk[SELECT_REG] and sets CNT_SER←0. SELECT_REG ≥NCHUNK loads zero.
  - Otherwise SER_SHIFT sets CNT_SER←sreg[0] and sreg←{0, sreg[SER_W-1:1]}.
  - LOAD wins over SHIFT in the same cycle.
  - Snapshot update and serialiser operate independently of state.

## Timing
- Reset (sampled at a CLK edge with RST=1):
  - STATE=INIT; TRIG, TRIGC all 1; TRIGE=1.
  - ptr=0, G=1, HIT_COUNT=0.
  - snapshot=0, sreg=0, CNT_SER=0.
  - Synchroniser cleared.
  - Reset mid-sampling or mid-shift takes effect at that edge.
- All outputs are registered; no combinational input-to-output path.
- Commands: pulse sampled at edge k → STATE, trigger outputs and snapshot updated at edge k.
- Discriminator: first sampled high at edge t → outputs update at edge t+SYNC_STAGES. Pulses must be high for ≥1 CLK period to be guaranteed.
- Serial: the chunk's bit j appears on CNT_SER after the (j+1)-th SER_SHIFT edge following the load.

## Structure
- Package psec_pkg holds:
  - the state_t enum with explicit 3-bit encoding (INIT=0, STOPPED=1, SAMPLING=2, SLOW_ONLY=3, READOUT=4);
  - the default parameter constants.
- Sub-module psec_cnt_serializer contains the snapshot register, chunk mux and shifter.
- The synchroniser, edge detect, FSM and trigger decode stay in the top module.

## Test plan
All scenarios use N_BANKS=4, CNT_W=10, SER_W=8 (NCHUNK=7).
- Reset, START with GROUP_LOG2=0 → TRIG=4'b1110, TRIGC=0000, TRIGE=0. Disc edge → TRIG=1101, TRIGC=0001. After 4 edges → STATE=SLOW_ONLY, TRIG=TRIGC=1111, TRIGE=0, HIT_COUNT=4.
- START with GROUP_LOG2=1 → TRIG=1100. Edge → TRIG=0011, TRIGC=0011. Edge → SLOW_ONLY. START with GROUP_LOG2=3 (clamped) → TRIG=0000; one edge → SLOW_ONLY.
- CNT bank0=10'h3A5, then STOP → STOPPED, all triggers 1. LOAD with SELECT_REG=0, then 8 shifts → CNT_SER sequence 1,0,1,0,0,1,0,1. SELECT_REG=7 → eight zeros.
- Disc edge in the same cycle as INST_STOP → STOPPED, HIT_COUNT unchanged. START during SAMPLING at ptr=2 → ptr=0, TRIG=1110. Disc held high 20 cycles → exactly one advance.
- RST asserted mid-SAMPLING and mid-shift → next edge: STATE=INIT, all triggers 1, CNT_SER=0, HIT_COUNT=0. A disc edge arriving SYNC_STAGES cycles later is ignored.

Source files
------------

// File: rtl/psec_pkg.sv
// Shared types and default parameters for the PSEC SCA sequencer.
// State encoding is fixed because STATE is read back over the readout path.
package psec_pkg;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    STOPPED   = 3'd1,
    SAMPLING  = 3'd2,
    SLOW_ONLY = 3'd3,
    READOUT   = 3'd4
  } state_t;

  localparam int N_BANKS_DEF     = 4;
  localparam int CNT_W_DEF       = 10;
  localparam int SER_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/psec_cnt_serializer.sv
// Counter snapshot register, chunk select and LSB-first shifter.
// The snapshot is zero-padded up to a whole number of serial chunks.
module psec_cnt_serializer
  import psec_pkg::*;
#(
  parameter int N_BANKS = N_BANKS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SER_W   = SER_W_DEF,
  parameter int NCHUNK  = ceil_div((N_BANKS + 1) * CNT_W, SER_W),
  parameter int SW      = $clog2(NCHUNK + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stop,
  input  logic [(N_BANKS+1)*CNT_W-1:0]   cnt,
  input  logic [SW-1:0]                  sel,
  input  logic                           load,
  input  logic                           shift,
  output logic                           cnt_ser
);

  localparam int SNAP_W = NCHUNK * SER_W;

  logic [SNAP_W-1:0] snapshot;
  logic [SER_W-1:0]  sreg;
  logic [SER_W-1:0]  chunk;

  // Chunk mux: a select past the last chunk shifts everything out, giving zero.
  always_comb begin
    chunk = SER_W'(snapshot >> (SER_W * int'(sel)));
  end

  // Snapshot capture and shifter; load takes precedence over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= '0;
      sreg     <= '0;
      cnt_ser  <= 1'b0;
    end else begin
      if (stop) begin
        snapshot <= SNAP_W'(cnt);
      end
      if (load) begin
        sreg    <= chunk;
        cnt_ser <= 1'b0;
      end else if (shift) begin
        cnt_ser <= sreg[0];
        sreg    <= {1'b0, sreg[SER_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/psec_sca_sequencer.sv
// SCA bank sequencer: discriminator synchroniser, group-stepping FSM and
// registered trigger decode; counter readout is delegated to the serializer.
module psec_sca_sequencer
  import psec_pkg::*;
#(
  parameter  int N_BANKS     = N_BANKS_DEF,
  parameter  int CNT_W       = CNT_W_DEF,
  parameter  int SER_W       = SER_W_DEF,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int GW          = $clog2($clog2(N_BANKS) + 1),
  localparam int NCHUNK      = ceil_div((N_BANKS + 1) * CNT_W, SER_W),
  localparam int SW          = $clog2(NCHUNK + 1),
  localparam int HW          = $clog2(N_BANKS + 1)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         INST_START,
  input  logic                         INST_STOP,
  input  logic                         INST_READOUT,
  input  logic [GW-1:0]                GROUP_LOG2,
  input  logic                         DISCRIMINATOR_OUTPUT,
  input  logic [(N_BANKS+1)*CNT_W-1:0] CNT,
  input  logic [SW-1:0]                SELECT_REG,
  input  logic                         LOAD_CNT_SER,
  input  logic                         SER_SHIFT,
  output logic [N_BANKS-1:0]           TRIG,
  output logic [N_BANKS-1:0]           TRIGC,
  output logic                         TRIGE,
  output logic [2:0]                   STATE,
  output logic [HW-1:0]                HIT_COUNT,
  output logic                         CNT_SER
);

  localparam int LOG2N = $clog2(N_BANKS);
  // ptr + G reaches at most 2*N_BANKS-1, so one extra bit covers it.
  localparam int PW = LOG2N + 1;
  localparam logic [HW-1:0] HMAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   disc_edge;

  state_t            state, nxt_state;
  logic [PW-1:0]     ptr, nxt_ptr, g, nxt_g, adv_ptr, nxt_end;
  logic [HW-1:0]     nxt_hit;
  logic [N_BANKS-1:0] nxt_trig, nxt_trigc;
  logic              nxt_trige;

  // Discriminator synchroniser plus one extra stage for rising-edge detect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], DISCRIMINATOR_OUTPUT};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign disc_edge = sync[SYNC_STAGES-1] & ~sync_prev;

  // Command priority: START > STOP > READOUT > discriminator edge.
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_g     = g;
    nxt_hit   = HIT_COUNT;
    adv_ptr   = ptr + g;
    if (INST_START) begin
      nxt_state = SAMPLING;
      nxt_ptr   = '0;
      nxt_hit   = '0;
      if (int'(GROUP_LOG2) > LOG2N) begin
        nxt_g = PW'(N_BANKS);
      end else begin
        nxt_g = PW'(1) << GROUP_LOG2;
      end
    end else if (INST_STOP) begin
      nxt_state = STOPPED;
    end else if (INST_READOUT) begin
      nxt_state = READOUT;
    end else if (disc_edge && (state == SAMPLING)) begin
      nxt_ptr = adv_ptr;
      if (HIT_COUNT != HMAX) begin
        nxt_hit = HIT_COUNT + HW'(1);
      end else begin
        nxt_hit = HIT_COUNT;
      end
      if (int'(adv_ptr) >= N_BANKS) begin
        nxt_state = SLOW_ONLY;
      end else begin
        nxt_state = SAMPLING;
      end
    end else begin
      nxt_state = state;
    end
  end

  // Trigger decode from the next state so the strobes are registered with it.
  always_comb begin
    nxt_trig  = '1;
    nxt_trigc = '1;
    nxt_trige = 1'b1;
    nxt_end   = nxt_ptr + nxt_g;
    case (nxt_state)
      SAMPLING: begin
        nxt_trige = 1'b0;
        for (int i = 0; i < N_BANKS; i++) begin
          if (PW'(i) < nxt_ptr) begin
            nxt_trig[i]  = 1'b1;
            nxt_trigc[i] = 1'b1;
          end else if (PW'(i) < nxt_end) begin
            nxt_trig[i]  = 1'b0;
            nxt_trigc[i] = 1'b0;
          end else begin
            nxt_trig[i]  = 1'b1;
            nxt_trigc[i] = 1'b0;
          end
        end
      end
      SLOW_ONLY: nxt_trige = 1'b0;
      default:   nxt_trige = 1'b1;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= INIT;
      ptr       <= '0;
      g         <= PW'(1);
      HIT_COUNT <= '0;
      TRIG      <= '1;
      TRIGC     <= '1;
      TRIGE     <= 1'b1;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      g         <= nxt_g;
      HIT_COUNT <= nxt_hit;
      TRIG      <= nxt_trig;
      TRIGC     <= nxt_trigc;
      TRIGE     <= nxt_trige;
    end
  end

  assign STATE = state;

  psec_cnt_serializer #(
    .N_BANKS (N_BANKS),
    .CNT_W   (CNT_W),
    .SER_W   (SER_W),
    .NCHUNK  (NCHUNK),
    .SW      (SW)
  ) u_ser (
    .clk     (CLK),
    .rst     (RST),
    .stop    (INST_STOP & ~INST_START),
    .cnt     (CNT),
    .sel     (SELECT_REG),
    .load    (LOAD_CNT_SER),
    .shift   (SER_SHIFT),
    .cnt_ser (CNT_SER)
  );

endmodule

// File: tb/tb_psec_sca_sequencer.sv
// Scoreboard bench for psec_sca_sequencer: a per-edge reference model pushes
// expected outputs into a queue; a negedge monitor pops and compares.
module tb_psec_sca_sequencer;
  import psec_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int SERW = 8;
  localparam int SS   = 2;
  localparam int NCH  = 7;
  localparam int GW   = 2;
  localparam int SELW = 3;
  localparam int HW   = 3;
  localparam int BUSW = (N + 1) * CW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0, stop = 1'b0, readout = 1'b0;
  logic [GW-1:0]   glog = '0;
  logic            disc = 1'b0;
  logic [BUSW-1:0] cnt = '0;
  logic [SELW-1:0] sel = '0;
  logic            load = 1'b0, shift = 1'b0;
  logic [N-1:0]    trig, trigc;
  logic            trige;
  logic [2:0]      st;
  logic [HW-1:0]   hit;
  logic            ser;

  always #5 clk = ~clk;

  psec_sca_sequencer #(
    .N_BANKS(N), .CNT_W(CW), .SER_W(SERW), .SYNC_STAGES(SS)
  ) dut (
    .CLK(clk), .RST(rst), .INST_START(start), .INST_STOP(stop),
    .INST_READOUT(readout), .GROUP_LOG2(glog), .DISCRIMINATOR_OUTPUT(disc),
    .CNT(cnt), .SELECT_REG(sel), .LOAD_CNT_SER(load), .SER_SHIFT(shift),
    .TRIG(trig), .TRIGC(trigc), .TRIGE(trige), .STATE(st),
    .HIT_COUNT(hit), .CNT_SER(ser)
  );

  typedef struct {
    logic [2:0]   st;
    logic [N-1:0] trig;
    logic [N-1:0] trigc;
    logic         trige;
    logic [HW-1:0] hit;
    logic         ser;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  state_t m_state = INIT;
  int     m_ptr = 0, m_g = 1, m_hit = 0;
  bit     snap[NCH*SERW];
  bit     sq[$];
  bit     m_ser = 1'b0;
  bit     hist[SS+1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.st = m_state;
    e.hit = HW'(m_hit);
    e.ser = m_ser;
    e.trig = '1;
    e.trigc = '1;
    e.trige = (m_state == SAMPLING || m_state == SLOW_ONLY) ? 1'b0 : 1'b1;
    if (m_state == SAMPLING) begin
      for (int i = 0; i < N; i++) begin
        if (i < m_ptr) begin
          e.trig[i] = 1'b1; e.trigc[i] = 1'b1;
        end else if (i < m_ptr + m_g) begin
          e.trig[i] = 1'b0; e.trigc[i] = 1'b0;
        end else begin
          e.trig[i] = 1'b1; e.trigc[i] = 1'b0;
        end
      end
    end
    return e;
  endfunction

  task automatic model_step();
    bit ev;
    int gl;
    if (rst) begin
      m_state = INIT; m_ptr = 0; m_g = 1; m_hit = 0; m_ser = 1'b0;
      for (int b = 0; b < NCH * SERW; b++) snap[b] = 1'b0;
      sq.delete();
      for (int j = 0; j <= SS; j++) hist[j] = 1'b0;
    end else begin
      // sample taken SS edges ago high, the one before it low
      ev = hist[SS-1] && !hist[SS];
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = disc;
      if (load) begin
        sq.delete();
        for (int b = 0; b < SERW; b++) begin
          if (int'(sel) < NCH) sq.push_back(snap[int'(sel) * SERW + b]);
          else sq.push_back(1'b0);
        end
        m_ser = 1'b0;
      end else if (shift) begin
        if (sq.size() > 0) m_ser = sq.pop_front();
        else m_ser = 1'b0;
      end
      if (start) begin
        gl = int'(glog);
        if (gl > $clog2(N)) gl = $clog2(N);
        m_g = 1 << gl; m_ptr = 0; m_hit = 0; m_state = SAMPLING;
      end else if (stop) begin
        m_state = STOPPED;
        for (int b = 0; b < NCH * SERW; b++) snap[b] = (b < BUSW) ? cnt[b] : 1'b0;
      end else if (readout) begin
        m_state = READOUT;
      end else if (ev && m_state == SAMPLING) begin
        m_ptr += m_g;
        m_hit = (m_hit < 7) ? m_hit + 1 : 7;
        if (m_ptr >= N) m_state = SLOW_ONLY;
      end
    end
  endtask

  task automatic tick();
    model_step();
    q.push_back(model_outputs());
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; readout = 1'b0; load = 1'b0; shift = 1'b0;
  endtask

  task automatic disc_pulse();
    disc = 1'b1; tick();
    disc = 1'b0; tick(); tick(); tick();
  endtask

  // Monitor: one expected record per clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(st), 32'(e.st));
      chk("trig", 32'(trig), 32'(e.trig));
      chk("trigc", 32'(trigc), 32'(e.trigc));
      chk("trige", 32'(trige), 32'(e.trige));
      chk("hit_count", 32'(hit), 32'(e.hit));
      chk("cnt_ser", 32'(ser), 32'(e.ser));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    int drain;
    pat = 8'hA5;

    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    chk("reset_state", 32'(st), 32'(3'd0));
    chk("reset_trig", 32'(trig), 32'(4'b1111));
    chk("reset_trige", 32'(trige), 32'(1'b1));

    // G=1 walk through all banks
    glog = 2'd0; start = 1'b1; tick();
    chk("g1_start_trig", 32'(trig), 32'(4'b1110));
    chk("g1_start_trigc", 32'(trigc), 32'(4'b0000));
    chk("g1_start_trige", 32'(trige), 32'(1'b0));
    disc_pulse();
    chk("g1_edge_trig", 32'(trig), 32'(4'b1101));
    chk("g1_edge_trigc", 32'(trigc), 32'(4'b0001));
    repeat (3) disc_pulse();
    chk("g1_slow_state", 32'(st), 32'(3'd3));
    chk("g1_slow_hits", 32'(hit), 32'(3'd4));
    chk("g1_slow_trig", 32'(trig), 32'(4'b1111));

    // G=2 and clamped G
    glog = 2'd1; start = 1'b1; tick();
    chk("g2_start_trig", 32'(trig), 32'(4'b1100));
    disc_pulse();
    chk("g2_edge_trig", 32'(trig), 32'(4'b0011));
    chk("g2_edge_trigc", 32'(trigc), 32'(4'b0011));
    disc_pulse();
    chk("g2_slow_state", 32'(st), 32'(3'd3));
    glog = 2'd3; start = 1'b1; tick();
    chk("gclamp_trig", 32'(trig), 32'(4'b0000));
    disc_pulse();
    chk("gclamp_slow_state", 32'(st), 32'(3'd3));

    // Snapshot and serial readout
    cnt = BUSW'({$urandom(), $urandom()});
    cnt[9:0] = 10'h3A5;
    stop = 1'b1; tick();
    chk("stop_state", 32'(st), 32'(3'd1));
    chk("stop_trig", 32'(trig), 32'(4'b1111));
    sel = 3'd0; load = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      shift = 1'b1; tick();
      chk("ser_a5_bit", 32'(ser), 32'(pat[k]));
    end
    sel = 3'd7; load = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      shift = 1'b1; tick();
      chk("ser_sel7_bit", 32'(ser), 32'(1'b0));
    end

    // Edge collides with STOP; restart mid-run; long high level
    glog = 2'd0; start = 1'b1; tick();
    disc = 1'b1; tick(); tick();
    stop = 1'b1; tick();
    chk("stop_vs_edge_state", 32'(st), 32'(3'd1));
    chk("stop_vs_edge_hits", 32'(hit), 32'(3'd0));
    disc = 1'b0; tick(); tick(); tick();
    start = 1'b1; tick();
    disc_pulse(); disc_pulse();
    start = 1'b1; tick();
    chk("restart_trig", 32'(trig), 32'(4'b1110));
    disc = 1'b1;
    repeat (20) tick();
    disc = 1'b0; tick(); tick(); tick();
    chk("held_level_hits", 32'(hit), 32'(3'd1));

    // Reset while sampling and shifting
    cnt = BUSW'({$urandom(), $urandom()});
    stop = 1'b1; tick();
    start = 1'b1; tick();
    disc_pulse();
    sel = 3'd1; load = 1'b1; tick();
    shift = 1'b1; tick();
    shift = 1'b1; disc = 1'b1; rst = 1'b1; tick();
    chk("midrst_state", 32'(st), 32'(3'd0));
    chk("midrst_trig", 32'(trig), 32'(4'b1111));
    chk("midrst_ser", 32'(ser), 32'(1'b0));
    chk("midrst_hits", 32'(hit), 32'(3'd0));
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_edge_ignored", 32'(st), 32'(3'd0));
    disc = 1'b0; tick();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      readout = ($urandom_range(0, 39) == 0);
      glog    = GW'($urandom_range(0, 3));
      sel     = SELW'($urandom_range(0, 7));
      load    = ($urandom_range(0, 7) == 0);
      shift   = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) disc = ~disc;
      if ($urandom_range(0, 9) == 0) cnt = BUSW'({$urandom(), $urandom()});
      tick();
    end
    rst = 1'b0;

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(negedge clk);
      #1;
      drain++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
